// File: rtl/audio_dac_serializer_if.sv
// Sample-pair handshake between the tone/mix producers and the DAC serializer.
// write_audio_out is the valid and audio_out_allowed the ready: a pair transfers on any
// CLOCK_50 rising edge where both are high, ready never depends on valid, and the sample
// buses only need to be meaningful while valid is high.
interface audio_dac_serializer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] left_channel_audio_out;
  logic [DATA_WIDTH-1:0] right_channel_audio_out;
  logic                  write_audio_out;
  logic                  audio_out_allowed;
  logic                  clear_audio_out_memory;

  modport master (
    output left_channel_audio_out,
    output right_channel_audio_out,
    output write_audio_out,
    output clear_audio_out_memory,
    input  audio_out_allowed
  );

  modport slave (
    input  left_channel_audio_out,
    input  right_channel_audio_out,
    input  write_audio_out,
    input  clear_audio_out_memory,
    output audio_out_allowed
  );
endinterface

// File: rtl/audio_dac_serializer.sv
// Stereo sample FIFO plus left-justified serializer driven by the codec's BCLK/LRCK,
// both resynchronised into the CLOCK_50 domain.
module audio_dac_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          Resetn,
  audio_dac_serializer_if.slave         snd,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_DACLRCK,
  output logic                          AUD_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow,
  output logic                          dbg_state_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  typedef enum logic {S_UNPRIMED = 1'b0, S_PRIMED = 1'b1} state_t;
  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem_l_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_r_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, hold_q, hold_d;
  logic                  lr_prev_q, lr_prev_d;
  logic                  underflow_q, underflow_d;
  logic                  dacdat_q, dacdat_d;
  logic                  bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic                  lrck_s1_q, lrck_s2_q;

  logic clear, fall_evt, primed, lr_rise, lr_fall, push, pop;

  assign clear    = snd.clear_audio_out_memory;
  assign fall_evt = bclk_s3_q & ~bclk_s2_q;
  assign primed   = (state_q == S_PRIMED);
  assign lr_rise  = fall_evt & primed & lrck_s2_q & ~lr_prev_q;
  assign lr_fall  = fall_evt & primed & ~lrck_s2_q & lr_prev_q;
  assign push     = snd.write_audio_out & snd.audio_out_allowed & ~clear;
  assign pop      = lr_rise & (level_q != '0) & ~clear;

  assign snd.audio_out_allowed = (level_q < DEPTH_L);
  assign fifo_level            = level_q;
  assign underflow             = underflow_q;
  assign AUD_DACDAT            = dacdat_q;
  assign dbg_state_o           = state_q;

  // The first BCLK fall after reset/clear only establishes lr_prev.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_UNPRIMED;
    end else if (fall_evt && state_q == S_UNPRIMED) begin
      state_d = S_PRIMED;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    lr_prev_d   = lr_prev_q;
    underflow_d = underflow_q;
    dacdat_d    = shift_q[DATA_WIDTH-1];
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      shift_d     = '0;
      hold_d      = '0;
      underflow_d = 1'b0;
      dacdat_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (fall_evt) lr_prev_d = lrck_s2_q;
      if (lr_rise) begin
        if (level_q != '0) begin
          shift_d = mem_l_q[rd_ptr_q];
          hold_d  = mem_r_q[rd_ptr_q];
        end else begin
          shift_d     = '0;
          hold_d      = '0;
          underflow_d = 1'b1;
        end
      end else if (lr_fall) begin
        shift_d = hold_q;
      end else if (fall_evt && primed) begin
        shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sample storage carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem_l_q[wr_ptr_q] <= snd.left_channel_audio_out;
      mem_r_q[wr_ptr_q] <= snd.right_channel_audio_out;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_UNPRIMED;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      lr_prev_q   <= 1'b0;
      underflow_q <= 1'b0;
      dacdat_q    <= 1'b0;
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_s3_q   <= 1'b0;
      lrck_s1_q   <= 1'b0;
      lrck_s2_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      lr_prev_q   <= lr_prev_d;
      underflow_q <= underflow_d;
      dacdat_q    <= dacdat_d;
      bclk_s1_q   <= AUD_BCLK;
      bclk_s2_q   <= bclk_s1_q;
      bclk_s3_q   <= bclk_s2_q;
      lrck_s1_q   <= AUD_DACLRCK;
      lrck_s2_q   <= lrck_s1_q;
    end
  end
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: frame-level model of the FIFO and serial stream,
// with every serial bit checked just before the BCLK rising edge.
`timescale 1ns/1ps
module tb_audio_dac_serializer;
  localparam int DW   = 32;
  localparam int FD   = 8;
  localparam int HALF = 163;

  logic          CLOCK_50;
  logic          Resetn;
  logic          AUD_BCLK;
  logic          AUD_DACLRCK;
  logic          AUD_DACDAT;
  logic [3:0]    fifo_level;
  logic          underflow;
  logic          dbg_state;

  audio_dac_serializer_if #(.DATA_WIDTH(DW)) snd ();

  audio_dac_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .CLOCK_50    (CLOCK_50),
    .Resetn      (Resetn),
    .snd         (snd),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .AUD_DACDAT  (AUD_DACDAT),
    .fifo_level  (fifo_level),
    .underflow   (underflow),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: each entry is {left, right}
  logic [2*DW-1:0] exp_q[$];
  bit              m_underflow;
  bit              m_primed;
  int              n_checks;
  int              n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_until(input longint t);
    if (t > longint'($time)) #(t - longint'($time));
  endtask

  task automatic check_status(input string tag);
    check({tag, "_level"},   32'(fifo_level), 32'(exp_q.size()));
    check({tag, "_allowed"}, 32'(snd.audio_out_allowed), 32'(exp_q.size() < FD));
    check({tag, "_uflow"},   32'(underflow), 32'(m_underflow));
  endtask

  // driver tasks
  task automatic do_reset();
    Resetn = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    Resetn = 1'b1;
    exp_q.delete();
    m_underflow = 1'b0;
    m_primed    = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge CLOCK_50);
    snd.clear_audio_out_memory = 1'b1;
    @(negedge CLOCK_50);
    snd.clear_audio_out_memory = 1'b0;
    exp_q.delete();
    m_underflow = 1'b0;
    m_primed    = 1'b0;
  endtask

  // Caller sits on a CLOCK_50 negedge; consecutive calls push one pair per cycle.
  task automatic push_pair(input logic [2*DW-1:0] p);
    snd.left_channel_audio_out  = p[2*DW-1:DW];
    snd.right_channel_audio_out = p[DW-1:0];
    snd.write_audio_out         = 1'b1;
    if (exp_q.size() < FD) exp_q.push_back(p);
    @(negedge CLOCK_50);
    check_status("push");
  endtask

  task automatic end_push();
    snd.write_audio_out = 1'b0;
  endtask

  task automatic push_one(input logic [2*DW-1:0] p);
    @(negedge CLOCK_50);
    push_pair(p);
    end_push();
  endtask

  // One BCLK fall with LRCK low: gives the serializer its reference LRCK level.
  task automatic prime();
    longint t0;
    AUD_DACLRCK = 1'b0;
    AUD_BCLK    = 1'b0;
    t0 = longint'($time);
    m_primed = 1'b1;
    wait_until(t0 + HALF - 35);
    @(negedge CLOCK_50);
    check("prime_state", 32'(dbg_state), 32'(m_primed));
    wait_until(t0 + HALF);
    AUD_BCLK = 1'b1;
    #(HALF);
  endtask

  // One 64-bit LRCK frame. Optionally pushes a pair in the exact cycle of the
  // frame-start pop, or pulses reset after the fall of bit rst_bit.
  task automatic drive_frame(input bit sim_push, input logic [2*DW-1:0] sp, input int rst_bit);
    logic [2*DW-1:0] cur;
    bit              zero_rest;
    bit              exp_bit;
    longint          t0;
    cur       = '0;
    zero_rest = 1'b0;
    for (int i = 0; i < 2*DW; i++) begin
      if (i == 0 && sim_push) @(negedge CLOCK_50);
      t0 = longint'($time);
      AUD_DACLRCK = (i < DW);
      AUD_BCLK    = 1'b0;
      if (i == 0) begin
        if (!m_primed) begin
          cur = '0;
        end else if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
        end else begin
          cur = '0;
          m_underflow = 1'b1;
        end
      end
      m_primed = 1'b1;
      if (i == 0 && sim_push) begin
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #1;
        snd.left_channel_audio_out  = sp[2*DW-1:DW];
        snd.right_channel_audio_out = sp[DW-1:0];
        snd.write_audio_out         = 1'b1;
        @(posedge CLOCK_50);
        #1;
        snd.write_audio_out = 1'b0;
        if (exp_q.size() < FD) exp_q.push_back(sp);
      end
      if (i == rst_bit) begin
        @(negedge CLOCK_50);
        Resetn = 1'b0;
        #1;
        check("rst_dacdat", 32'(AUD_DACDAT), 32'd0);
        repeat (5) @(negedge CLOCK_50);
        Resetn = 1'b1;
        exp_q.delete();
        m_underflow = 1'b0;
        m_primed    = 1'b0;
        zero_rest   = 1'b1;
      end
      exp_bit = zero_rest ? 1'b0 : cur[2*DW-1-i];
      wait_until(t0 + HALF - 35);
      @(negedge CLOCK_50);
      check("dacdat", 32'(AUD_DACDAT), 32'(exp_bit));
      check("state", 32'(dbg_state), 32'(m_primed));
      check_status("frame");
      wait_until(t0 + HALF);
      AUD_BCLK = 1'b1;
      t0 = longint'($time);
      wait_until(t0 + HALF);
    end
  endtask

  function automatic logic [2*DW-1:0] rand_pair();
    return {$urandom, $urandom};
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    AUD_BCLK    = 1'b1;
    AUD_DACLRCK = 1'b0;
    snd.left_channel_audio_out  = '0;
    snd.right_channel_audio_out = '0;
    snd.write_audio_out         = 1'b0;
    snd.clear_audio_out_memory  = 1'b0;
    do_reset();
    @(negedge CLOCK_50);
    check("rst_dacdat", 32'(AUD_DACDAT), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check_status("rst");

    // single known pair
    push_one({32'h8000_0001, 32'h7FFF_FFFE});
    prime();
    drive_frame(1'b0, '0, -1);

    // fill past capacity with BCLK idle, then drain
    @(negedge CLOCK_50);
    for (int k = 0; k < FD + 1; k++) push_pair(rand_pair());
    end_push();
    for (int k = 0; k < FD; k++) drive_frame(1'b0, '0, -1);

    // underflow, then clear
    drive_frame(1'b0, '0, -1);
    drive_frame(1'b0, '0, -1);
    check("uflow_sticky", 32'(underflow), 32'd1);
    do_clear();
    @(negedge CLOCK_50);
    check("clear_state", 32'(dbg_state), 32'd0);
    check_status("clear");

    // push coincident with the frame-start pop at level 3
    for (int k = 0; k < 3; k++) push_one(rand_pair());
    prime();
    drive_frame(1'b1, rand_pair(), -1);
    check("simul_level", 32'(fifo_level), 32'd3);
    for (int k = 0; k < 3; k++) drive_frame(1'b0, '0, -1);

    // reset during bit 10 of the left half
    push_one(rand_pair());
    drive_frame(1'b0, '0, 10);
    push_one(rand_pair());
    drive_frame(1'b0, '0, -1);

    // BCLK phase sweep against CLOCK_50
    for (int off = 0; off < 20; off++) begin
      #(off);
      push_one(rand_pair());
      #(off);
      drive_frame(1'b0, '0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/audio_dac_serializer.md
# audio_dac_serializer

Sample-output back end for the codec audio path. It accepts stereo sample pairs from the tone and mix logic through the `audio_out_allowed` / `write_audio_out` handshake and buffers them in a small FIFO. It serializes each pair MSB-first onto `AUD_DACDAT` in left-justified format, timed by the codec-driven `AUD_BCLK` and `AUD_DACLRCK`. It is the consumer end of the sample interface that the note generators drive.

## Interface
Parameters:
- `DATA_WIDTH`, 32: bits per channel sample.
- `FIFO_DEPTH`, 8: stereo pairs buffered; must be a power of 2, minimum 2.

Ports:
- `CLOCK_50`, input, 1: system clock; all logic is synchronous to its rising edge.
- `Resetn`, input, 1: asynchronous, active-low reset.
- `clear_audio_out_memory`, input, 1: synchronous flush.
- `left_channel_audio_out`, input, DATA_WIDTH: left sample, two's complement.
- `right_channel_audio_out`, input, DATA_WIDTH: right sample, two's complement.
- `write_audio_out`, input, 1: push request.
- `audio_out_allowed`, output, 1: FIFO has at least one free pair slot.
- `AUD_BCLK`, input, 1: codec bit clock, asynchronous to `CLOCK_50`.
- `AUD_DACLRCK`, input, 1: codec frame clock, asynchronous; high = left channel.
- `AUD_DACDAT`, output, 1: serial data to codec.
- `fifo_level`, output, log2(FIFO_DEPTH)+1: pairs currently stored.
- `underflow`, output, 1: sticky; a frame started with the FIFO empty.

## Operation
- **Push:** a pair is written when `write_audio_out && audio_out_allowed`. `audio_out_allowed = (fifo_level < FIFO_DEPTH)`, derived from the registered level. A write while full is dropped silently.
- **Synchronizers:** `AUD_BCLK` and `AUD_DACLRCK` each pass through 2 flops, plus a third flop on BCLK for edge detection. A BCLK fall event is sync2=0 and sync3=1.
- **Priming:**
  - After reset or clear, `primed`=0.
  - The first BCLK fall event only records LRCK into `lr_prev` and sets `primed`=1.
- **Each BCLK fall event with `primed`=1:**
  - LRCK 0→1 (left frame start):
    - If the FIFO is non-empty: pop one pair, load left into the shift register, store right in the hold register.
    - If the FIFO is empty: load zero into both, set `underflow`.
  - LRCK 1→0: load the hold register into the shift register.
  - No LRCK change: shift left 1, zero fill. Bits past DATA_WIDTH within a half-frame are therefore 0.
  - `lr_prev` is updated on every event.
- **Output:** `AUD_DACDAT` is the registered shift register MSB.
- **Simultaneous push and pop:** both take effect and the level is unchanged. Push into a full FIFO while a pop occurs in the same cycle is still rejected, because `audio_out_allowed` was 0.
- **Clear (`clear_audio_out_memory`=1):** it takes priority over push and pop in that cycle. On the next edge:
  - level = 0 and pointers = 0;
  - shift and hold registers = 0;
  - `underflow` = 0 and `primed` = 0.
- **Reset values:** `AUD_DACDAT`=0, `fifo_level`=0, `audio_out_allowed`=1, `underflow`=0, synchronizers 0, `primed`=0.
- **Reset mid-frame:** output goes to 0 immediately. No data is emitted until the first full LRCK 0→1 after re-priming.
- **Pointer arithmetic:** pointers wrap modulo FIFO_DEPTH. The level counter is never allowed to exceed FIFO_DEPTH or go below 0.

## Timing
- **Serial path:** a BCLK falling edge at the pin reaches `AUD_DACDAT` within 4 `CLOCK_50` cycles (80 ns). This is inside the BCLK half-period at 3.072 MHz (163 ns), so the codec samples stable data on the rising edge.
- **Handshake:** a push is visible in `fifo_level` on the next `CLOCK_50` edge. `audio_out_allowed` drops the cycle after the FIFO becomes full.
- **Pop:** happens in the same cycle as the LRCK 0→1 fall event; the level decrements on that edge.
- **Throughput:** sustains 1 pair per LRCK period. The producer may push at up to 1 pair per `CLOCK_50` cycle until full.

## Test plan
- **Single pair:** reset, push L=32'h8000_0001, R=32'h7FFF_FFFE, then drive 48 kHz frames (BCLK 3.072 MHz, 32 bits per half). Required: the left half serializes 1000…0001 and the right half 0111…1110, MSB first, each bit stable at BCLK rise.
- **Fill and overflow:** push 9 pairs back-to-back with no BCLK. Required: `fifo_level`=8 and `audio_out_allowed`=0 after the 8th; the 9th is dropped; the output later shows pairs 1–8 in order.
- **Underflow:** run 2 frames with an empty FIFO. Required: `AUD_DACDAT`=0 throughout and `underflow`=1 from the first LRCK rise. A subsequent `clear_audio_out_memory` pulse returns `underflow` to 0.
- **Simultaneous push and pop:** with level=3, assert a push in the exact cycle of an LRCK-rise pop. Required: level stays 3 and data order is preserved.
- **Reset mid-frame:** assert `Resetn`=0 at bit 10 of a left half, release it 5 cycles later. Required: `AUD_DACDAT`=0 immediately, and no data until the next complete frame after priming.
- **Asynchronous phase sweep:** sweep BCLK phase relative to `CLOCK_50` across 20 offsets. Required: no missed or duplicated bits, checked against a reference model.
